// File: rtl/relay_coil_sequencer_if.sv
// ---------------------------------------------------------------------------
// relay_coil_sequencer_if
//
// Purpose:
//    Bundles the command strobe coming from the relay register wrapper and the
//    status / coil-drive signals produced by relay_coil_sequencer.
//
// Signals:
//    toggle_en       command strobe, one cycle wide
//    toggle_dir      1 = switch relay in (drive A side), 0 = switch out (B side)
//    toggle_channel  relay index 0..3
//    toggle_done     one-cycle pulse when a command has fully completed
//    busy            high while a command is in progress
//    cmd_dropped     one-cycle pulse when a strobe was rejected
//    relay_a         H-bridge A-side drive, one bit per relay
//    relay_b         H-bridge B-side drive, one bit per relay
//
// Modports:
//    master  the command issuer (register wrapper or testbench)
//    slave   the sequencer itself
// ---------------------------------------------------------------------------
interface relay_coil_sequencer_if;

   logic       toggle_en;
   logic       toggle_dir;
   logic [1:0] toggle_channel;
   logic       toggle_done;
   logic       busy;
   logic       cmd_dropped;
   logic [3:0] relay_a;
   logic [3:0] relay_b;

   modport master (
      output toggle_en,
      output toggle_dir,
      output toggle_channel,
      input  toggle_done,
      input  busy,
      input  cmd_dropped,
      input  relay_a,
      input  relay_b
   );

   modport slave (
      input  toggle_en,
      input  toggle_dir,
      input  toggle_channel,
      output toggle_done,
      output busy,
      output cmd_dropped,
      output relay_a,
      output relay_b
   );

endinterface

// File: rtl/relay_coil_sequencer.sv
// ---------------------------------------------------------------------------
// relay_coil_sequencer
//
// Purpose:
//    Self-timed coil driver for four latching relays. A command strobe picks a
//    relay and a direction; the block then produces an outputs-low guard
//    interval, a single-polarity H-bridge drive pulse, an outputs-low
//    mechanical settle interval, and finally a one-cycle toggle_done pulse.
//    All outputs are registered so the coil drivers never see combinational
//    glitches.
//
// Ports:
//    clk_250mhz  single clock (APB pclk)
//    rst_n       asynchronous active-low reset; de-energises coils at once
//    bus         relay_coil_sequencer_if.slave
//                  in : toggle_en, toggle_dir, toggle_channel
//                  out: toggle_done, busy, cmd_dropped, relay_a, relay_b
//
// Parameters:
//    PULSE_CYCLES   coil drive length in clocks, must be >= 1
//    DEAD_CYCLES    outputs-low guard before the drive pulse, 0 skips it
//    SETTLE_CYCLES  outputs-low settle time after the drive pulse, 0 skips it
//
// Build option:
//    RELAY_CMD_QUEUE_EN  when defined, a one-entry pending buffer holds a
//                        single command received while busy and launches it
//                        straight out of the DONE cycle.
// ---------------------------------------------------------------------------
module relay_coil_sequencer #(
   parameter int PULSE_CYCLES  = 1250000,
   parameter int DEAD_CYCLES   = 250,
   parameter int SETTLE_CYCLES = 2500000
) (
   input  logic                  clk_250mhz,
   input  logic                  rst_n,
   relay_coil_sequencer_if.slave bus
);

   // A zero-length drive pulse would make the whole sequence meaningless.
   generate
      if (PULSE_CYCLES < 1) begin : g_badPulseCycles
         $error("relay_coil_sequencer: PULSE_CYCLES must be >= 1");
      end
   endgenerate

   // One down-counter serves every timed phase, so it is sized for the
   // longest of them.
   localparam int MAX_DP  = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES : DEAD_CYCLES;
   localparam int MAX_ALL = (MAX_DP > SETTLE_CYCLES) ? MAX_DP : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   // A phase of N cycles loads N-1 and ends on the cycle the counter reads 0.
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD   = (DEAD_CYCLES > 0)   ? CNT_W'(DEAD_CYCLES - 1)   : '0;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREDEAD,
      S_DRIVE,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_ch;
   logic             r_dir;
   logic             r_busy;
   logic             r_toggleDone;
   logic             r_cmdDropped;
   logic [3:0]       r_relayA;
   logic [3:0]       r_relayB;

`ifdef RELAY_CMD_QUEUE_EN
   logic             r_qValid;
   logic [1:0]       r_qCh;
   logic             r_qDir;
   logic             w_store;
`endif

   logic             w_startNow;
   logic             w_drop;
   logic [1:0]       w_startCh;
   logic             w_startDir;
   logic [3:0]       w_startA;
   logic [3:0]       w_startB;
   logic [3:0]       w_holdA;
   logic [3:0]       w_holdB;

   function automatic logic [3:0] f_channelMask(input logic [1:0] ch);
      f_channelMask = 4'b0001 << ch;
   endfunction

   // Selects the command that would be launched this cycle. A buffered
   // command always has priority over a fresh strobe because it arrived first.
   always_comb begin
      w_startCh  = bus.toggle_channel;
      w_startDir = bus.toggle_dir;
`ifdef RELAY_CMD_QUEUE_EN
      if (r_qValid) begin
         w_startCh  = r_qCh;
         w_startDir = r_qDir;
      end
`endif
   end

`ifdef RELAY_CMD_QUEUE_EN
   // With the buffer present a new command can start from IDLE, or directly
   // out of DONE when either the buffer holds one or a strobe arrives while the
   // buffer is empty (that strobe is as good as stored and consumed at once).
   // Only a strobe that meets a full buffer is rejected.
   assign w_startNow = ((r_state == S_IDLE) && bus.toggle_en) ||
                       ((r_state == S_DONE) && (r_qValid || bus.toggle_en));
   assign w_drop     = bus.toggle_en && (r_state != S_IDLE) && r_qValid;
   assign w_store    = bus.toggle_en && (r_state != S_IDLE) && (r_state != S_DONE) && !r_qValid;
`else
   // Without the buffer only IDLE accepts; every other strobe is rejected.
   assign w_startNow = (r_state == S_IDLE) && bus.toggle_en;
   assign w_drop     = bus.toggle_en && (r_state != S_IDLE);
`endif

   // Coil patterns for a command being launched straight into DRIVE, and for
   // the latched command when PREDEAD hands over to DRIVE.
   assign w_startA = w_startDir  ? f_channelMask(w_startCh) : 4'b0000;
   assign w_startB = !w_startDir ? f_channelMask(w_startCh) : 4'b0000;
   assign w_holdA  = r_dir       ? f_channelMask(r_ch)      : 4'b0000;
   assign w_holdB  = !r_dir      ? f_channelMask(r_ch)      : 4'b0000;

   // Sequencer state machine. Every output is a register written here so
   // relay_a/relay_b can only ever be energised in DRIVE, and every DRIVE is
   // bracketed by states whose coil outputs are all zero.
   always_ff @(posedge clk_250mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_ch         <= 2'b00;
         r_dir        <= 1'b0;
         r_busy       <= 1'b0;
         r_toggleDone <= 1'b0;
         r_cmdDropped <= 1'b0;
         r_relayA     <= 4'b0000;
         r_relayB     <= 4'b0000;
`ifdef RELAY_CMD_QUEUE_EN
         r_qValid     <= 1'b0;
         r_qCh        <= 2'b00;
         r_qDir       <= 1'b0;
`endif
      end else begin
         r_cmdDropped <= w_drop;
         r_toggleDone <= 1'b0;

         if (w_startNow) begin
            r_ch   <= w_startCh;
            r_dir  <= w_startDir;
            r_busy <= 1'b1;
            if (DEAD_CYCLES > 0) begin
               r_state  <= S_PREDEAD;
               r_count  <= DEAD_LOAD;
               r_relayA <= 4'b0000;
               r_relayB <= 4'b0000;
            end else begin
               r_state  <= S_DRIVE;
               r_count  <= PULSE_LOAD;
               r_relayA <= w_startA;
               r_relayB <= w_startB;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_busy   <= 1'b0;
                  r_relayA <= 4'b0000;
                  r_relayB <= 4'b0000;
               end

               S_PREDEAD: begin
                  if (r_count == '0) begin
                     r_state  <= S_DRIVE;
                     r_count  <= PULSE_LOAD;
                     r_relayA <= w_holdA;
                     r_relayB <= w_holdB;
                  end else begin
                     r_count <= r_count - CNT_W'(1);
                  end
               end

               S_DRIVE: begin
                  if (r_count == '0) begin
                     r_relayA <= 4'b0000;
                     r_relayB <= 4'b0000;
                     if (SETTLE_CYCLES > 0) begin
                        r_state <= S_SETTLE;
                        r_count <= SETTLE_LOAD;
                     end else begin
                        r_state      <= S_DONE;
                        r_toggleDone <= 1'b1;
                     end
                  end else begin
                     r_count <= r_count - CNT_W'(1);
                  end
               end

               S_SETTLE: begin
                  if (r_count == '0) begin
                     r_state      <= S_DONE;
                     r_toggleDone <= 1'b1;
                  end else begin
                     r_count <= r_count - CNT_W'(1);
                  end
               end

               S_DONE: begin
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_relayA <= 4'b0000;
                  r_relayB <= 4'b0000;
               end

               default: begin
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_count  <= '0;
                  r_relayA <= 4'b0000;
                  r_relayB <= 4'b0000;
               end
            endcase
         end

`ifdef RELAY_CMD_QUEUE_EN
         // The buffer fills from a strobe during a busy phase and is emptied
         // by the DONE cycle, which launches whatever it held.
         if (w_store) begin
            r_qValid <= 1'b1;
            r_qCh    <= bus.toggle_channel;
            r_qDir   <= bus.toggle_dir;
         end else if (r_state == S_DONE) begin
            r_qValid <= 1'b0;
         end
`endif
      end
   end

   assign bus.toggle_done = r_toggleDone;
   assign bus.busy        = r_busy;
   assign bus.cmd_dropped = r_cmdDropped;
   assign bus.relay_a     = r_relayA;
   assign bus.relay_b     = r_relayB;

endmodule

// File: tb/tb_relay_coil_sequencer.sv
// ---------------------------------------------------------------------------
// tb_relay_coil_sequencer
//
// Drives two sequencer instances from one clock: dutA with PULSE=8, DEAD=2,
// SETTLE=4 and dutB with PULSE=1, DEAD=0, SETTLE=0. A timeline model predicts
// every output from the cycle offset since a command was accepted.
// ---------------------------------------------------------------------------
module tb_relay_coil_sequencer;

   logic clk;
   logic rst_n;

   relay_coil_sequencer_if ifA ();
   relay_coil_sequencer_if ifB ();

   relay_coil_sequencer #(
      .PULSE_CYCLES  (8),
      .DEAD_CYCLES   (2),
      .SETTLE_CYCLES (4)
   ) dutA (
      .clk_250mhz (clk),
      .rst_n      (rst_n),
      .bus        (ifA)
   );

   relay_coil_sequencer #(
      .PULSE_CYCLES  (1),
      .DEAD_CYCLES   (0),
      .SETTLE_CYCLES (0)
   ) dutB (
      .clk_250mhz (clk),
      .rst_n      (rst_n),
      .bus        (ifB)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int cyc        = 0;

   // Timeline model: per DUT, the cycle in which the current command was
   // accepted plus the latched command; phase lengths come from the params.
   int         pDead[2]   = '{2, 0};
   int         pPulse[2]  = '{8, 1};
   int         pSettle[2] = '{4, 0};
   bit         mActive[2];
   int         mStart[2];
   logic [1:0] mCh[2];
   logic       mDir[2];
   bit         qValid[2];
   logic [1:0] qCh[2];
   logic       qDir[2];
   logic       expDrop[2];

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input int i, input logic [1:0] ch, input logic dir);
      mActive[i] = 1'b1;
      mStart[i]  = cyc;
      mCh[i]     = ch;
      mDir[i]    = dir;
   endtask

   // Decides, from the inputs presented in the current cycle, what each DUT
   // does at the coming edge.
   task automatic modelEdge(input int i, input logic en, input logic dir, input logic [1:0] ch);
      int total;
      int off;
      bit act;
      total      = pDead[i] + pPulse[i] + pSettle[i] + 1;
      off        = cyc - mStart[i];
      act        = mActive[i] && (off >= 1) && (off <= total);
      expDrop[i] = 1'b0;
      if (!act) begin
         if (en) launch(i, ch, dir);
      end else if (off == total) begin
`ifdef RELAY_CMD_QUEUE_EN
         if (qValid[i]) begin
            launch(i, qCh[i], qDir[i]);
            qValid[i] = 1'b0;
            if (en) expDrop[i] = 1'b1;
         end else if (en) begin
            launch(i, ch, dir);
         end
`else
         if (en) expDrop[i] = 1'b1;
`endif
      end else begin
`ifdef RELAY_CMD_QUEUE_EN
         if (en) begin
            if (qValid[i]) expDrop[i] = 1'b1;
            else begin
               qValid[i] = 1'b1;
               qCh[i]    = ch;
               qDir[i]   = dir;
            end
         end
`else
         if (en) expDrop[i] = 1'b1;
`endif
      end
   endtask

   // Compares one DUT against the model for the cycle just entered.
   task automatic checkDut(input int i);
      int         total;
      int         off;
      bit         inSeq;
      bit         drv;
      logic [3:0] expA;
      logic [3:0] expB;
      logic [3:0] obsA;
      logic [3:0] obsB;
      logic       obsBusy;
      logic       obsDone;
      logic       obsDrop;
      string      pfx;
      total = pDead[i] + pPulse[i] + pSettle[i] + 1;
      off   = cyc - mStart[i];
      inSeq = mActive[i] && (off >= 1) && (off <= total);
      drv   = inSeq && (off > pDead[i]) && (off <= pDead[i] + pPulse[i]);
      expA  = (drv && mDir[i])  ? (4'b0001 << mCh[i]) : 4'b0000;
      expB  = (drv && !mDir[i]) ? (4'b0001 << mCh[i]) : 4'b0000;
      if (i == 0) begin
         pfx = "A"; obsA = ifA.relay_a; obsB = ifA.relay_b; obsBusy = ifA.busy;
         obsDone = ifA.toggle_done; obsDrop = ifA.cmd_dropped;
      end else begin
         pfx = "B"; obsA = ifB.relay_a; obsB = ifB.relay_b; obsBusy = ifB.busy;
         obsDone = ifB.toggle_done; obsDrop = ifB.cmd_dropped;
      end
      checkOutput($sformatf("%s_relay_a@%0d", pfx, cyc), obsA, expA);
      checkOutput($sformatf("%s_relay_b@%0d", pfx, cyc), obsB, expB);
      checkOutput($sformatf("%s_busy@%0d", pfx, cyc), {3'b000, obsBusy}, {3'b000, inSeq});
      checkOutput($sformatf("%s_done@%0d", pfx, cyc), {3'b000, obsDone}, {3'b000, (inSeq && off == total)});
      checkOutput($sformatf("%s_dropped@%0d", pfx, cyc), {3'b000, obsDrop}, {3'b000, expDrop[i]});
      checkOutput($sformatf("%s_a_and_b@%0d", pfx, cyc), obsA & obsB, 4'b0000);
   endtask

   // Presents one cycle of inputs to both DUTs, clocks, and checks both.
   task automatic applyStimulus(input logic en0, input logic dir0, input logic [1:0] ch0,
                                input logic en1, input logic dir1, input logic [1:0] ch1);
      ifA.toggle_en = en0; ifA.toggle_dir = dir0; ifA.toggle_channel = ch0;
      ifB.toggle_en = en1; ifB.toggle_dir = dir1; ifB.toggle_channel = ch1;
      modelEdge(0, en0, dir0, ch0);
      modelEdge(1, en1, dir1, ch1);
      @(posedge clk);
      #1;
      cyc++;
      ifA.toggle_en = 1'b0;
      ifB.toggle_en = 1'b0;
      checkDut(0);
      checkDut(1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_A_relay_a"}, ifA.relay_a, 4'b0000);
      checkOutput({tag, "_A_relay_b"}, ifA.relay_b, 4'b0000);
      checkOutput({tag, "_A_busy"}, {3'b000, ifA.busy}, 4'b0000);
      checkOutput({tag, "_A_done"}, {3'b000, ifA.toggle_done}, 4'b0000);
      checkOutput({tag, "_A_dropped"}, {3'b000, ifA.cmd_dropped}, 4'b0000);
      checkOutput({tag, "_B_relay_a"}, ifB.relay_a, 4'b0000);
      checkOutput({tag, "_B_relay_b"}, ifB.relay_b, 4'b0000);
      checkOutput({tag, "_B_busy"}, {3'b000, ifB.busy}, 4'b0000);
   endtask

   task automatic resetModel();
      for (int i = 0; i < 2; i++) begin
         mActive[i] = 1'b0;
         qValid[i]  = 1'b0;
         expDrop[i] = 1'b0;
      end
   endtask

   // Directed test-plan sequences followed by a randomized run.
   initial begin
      rst_n = 1'b0;
      ifA.toggle_en = 1'b0; ifA.toggle_dir = 1'b0; ifA.toggle_channel = 2'd0;
      ifB.toggle_en = 1'b0; ifB.toggle_dir = 1'b0; ifB.toggle_channel = 2'd0;
      resetModel();
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] basic in: ch=2 dir=1");
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
      for (int k = 2; k <= 16; k++) begin
         applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
         if (k == 2)  checkOutput("basicIn_a_c2", ifA.relay_a, 4'b0000);
         if (k == 3)  checkOutput("basicIn_a_c3", ifA.relay_a, 4'b0100);
         if (k == 10) checkOutput("basicIn_a_c10", ifA.relay_a, 4'b0100);
         if (k == 11) checkOutput("basicIn_a_c11", ifA.relay_a, 4'b0000);
         if (k == 15) checkOutput("basicIn_done_c15", {3'b000, ifA.toggle_done}, 4'b0001);
         if (k == 16) checkOutput("basicIn_busy_c16", {3'b000, ifA.busy}, 4'b0000);
      end

      $display("[TB] basic out: ch=0 dir=0");
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
      for (int k = 2; k <= 16; k++) begin
         applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
         if (k == 3)  checkOutput("basicOut_b_c3", ifA.relay_b, 4'b0001);
         if (k == 10) checkOutput("basicOut_b_c10", ifA.relay_b, 4'b0001);
         if (k == 11) checkOutput("basicOut_b_c11", ifA.relay_b, 4'b0000);
         if (k == 15) checkOutput("basicOut_done_c15", {3'b000, ifA.toggle_done}, 4'b0001);
      end

      $display("[TB] strobes while busy");
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
      idle(4);
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
`ifdef RELAY_CMD_QUEUE_EN
      checkOutput("busyStrobe_dropped_c6", {3'b000, ifA.cmd_dropped}, 4'b0000);
`else
      checkOutput("busyStrobe_dropped_c6", {3'b000, ifA.cmd_dropped}, 4'b0001);
`endif
      applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
      checkOutput("busyStrobe_dropped_c7", {3'b000, ifA.cmd_dropped}, 4'b0001);
      idle(25);

      $display("[TB] reset mid-drive");
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
      idle(5);
      checkOutput("preReset_a_c6", ifA.relay_a, 4'b0010);
      rst_n = 1'b0;
      #1;
      checkAllZero("asyncReset");
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0);
      idle(16);

      $display("[TB] zero dead/settle back-to-back");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);
      checkOutput("fast_b_c1", ifB.relay_b, 4'b0010);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
      checkOutput("fast_done_c2", {3'b000, ifB.toggle_done}, 4'b0001);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2);
      checkOutput("fast_a_c4", ifB.relay_a, 4'b0100);
      idle(3);

      $display("[TB] randomized commands");
      for (int n = 0; n < 600; n++) begin
         applyStimulus(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      idle(20);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
